// File: rtl/hive_damage_ctrl.sv
// Erases a 3x3 patch of a hive sprite RAM around a bullet/bomb hit, writing only during vertical blank.
// Ack one cycle after req; first write two cycles after ack; pauses (holding its place) whenever vbl drops.
module hive_damage_ctrl #(
    parameter int         HIVE_W    = 56,
    parameter int         HIVE_H    = 39,
    parameter logic [7:0] ERASE_VAL = 8'h00
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic        vbl,
    input  logic        req_p,
    input  logic        req_b,
    input  logic [1:0]  hive_p,
    input  logic [1:0]  hive_b,
    input  logic [5:0]  hx_p,
    input  logic [5:0]  hx_b,
    input  logic [5:0]  hy_p,
    input  logic [5:0]  hy_b,
    output logic        ack_p,
    output logic        ack_b,
    output logic        ram_own,
    output logic        wr_en,
    output logic [3:0]  wr_hive,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        ERASE      = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [3:0]  idx_q, idx_d;
    logic        last_b_q, last_b_d;
    logic [1:0]  hive_q, hive_d;
    logic [5:0]  hx_q, hx_d;
    logic [5:0]  hy_q, hy_d;

    logic        ack_p_q, ack_p_d;
    logic        ack_b_q, ack_b_d;
    logic        ram_own_q, ram_own_d;
    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_hive_q, wr_hive_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic              grant;
    logic              grant_b;
    logic              visit;
    logic [1:0]        row;
    logic [1:0]        col;
    logic signed [7:0] x_s;
    logic signed [7:0] y_s;
    logic              in_bounds;
    logic [11:0]       cell_addr;

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        grant   = (state_q == IDLE) && (req_p || req_b);
        grant_b = (req_p && req_b) ? !last_b_q : req_b;
    end

    always_comb begin
        row = 2'd0;
        col = 2'd0;
        case (idx_q)
            4'd0: begin row = 2'd0; col = 2'd0; end
            4'd1: begin row = 2'd0; col = 2'd1; end
            4'd2: begin row = 2'd0; col = 2'd2; end
            4'd3: begin row = 2'd1; col = 2'd0; end
            4'd4: begin row = 2'd1; col = 2'd1; end
            4'd5: begin row = 2'd1; col = 2'd2; end
            4'd6: begin row = 2'd2; col = 2'd0; end
            4'd7: begin row = 2'd2; col = 2'd1; end
            4'd8: begin row = 2'd2; col = 2'd2; end
            default: begin row = 2'd0; col = 2'd0; end
        endcase
    end

    // Coordinates are signed so a hit at x=0/y=0 yields -1 and is clipped, not wrapped.
    always_comb begin
        x_s       = $signed({2'b00, hx_q}) + $signed({6'b000000, col}) - 8'sd1;
        y_s       = $signed({2'b00, hy_q}) + $signed({6'b000000, row}) - 8'sd1;
        in_bounds = !x_s[7] && (int'(x_s) < HIVE_W) &&
                    !y_s[7] && (int'(y_s) < HIVE_H);
        cell_addr = 12'(y_s[6:0]) * 12'(HIVE_W) + 12'(x_s[6:0]);
        visit     = (state_q == ERASE) && (idx_q < 4'd9) && vbl;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (grant) state_d = WAIT_BLANK;
            WAIT_BLANK: if (vbl) state_d = ERASE;
            ERASE:      if (idx_q == 4'd9) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_p_d   = grant && !grant_b;
        ack_b_d   = grant && grant_b;
        busy_d    = (state_d == WAIT_BLANK) || (state_d == ERASE);
        done_d    = (state_q == ERASE) && (idx_q == 4'd9);
        ram_own_d = visit;
        wr_en_d   = visit && in_bounds;
        wr_hive_d = wr_en_d ? (4'b0001 << hive_q) : 4'b0000;
        wr_addr_d = wr_en_d ? cell_addr : 12'd0;
    end

    always_comb begin
        idx_d    = idx_q;
        last_b_d = last_b_q;
        hive_d   = hive_q;
        hx_d     = hx_q;
        hy_d     = hy_q;
        if (grant) begin
            idx_d    = 4'd0;
            last_b_d = grant_b;
            hive_d   = grant_b ? hive_b : hive_p;
            hx_d     = grant_b ? hx_b : hx_p;
            hy_d     = grant_b ? hy_b : hy_p;
        end else if (visit) begin
            idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            idx_q     <= 4'd0;
            last_b_q  <= 1'b1;
            hive_q    <= 2'd0;
            hx_q      <= 6'd0;
            hy_q      <= 6'd0;
            ack_p_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            ram_own_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_hive_q <= 4'd0;
            wr_addr_q <= 12'd0;
            wr_data_q <= ERASE_VAL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            last_b_q  <= last_b_d;
            hive_q    <= hive_d;
            hx_q      <= hx_d;
            hy_q      <= hy_d;
            ack_p_q   <= ack_p_d;
            ack_b_q   <= ack_b_d;
            ram_own_q <= ram_own_d;
            wr_en_q   <= wr_en_d;
            wr_hive_q <= wr_hive_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= ERASE_VAL;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ack_p   = ack_p_q;
    assign ack_b   = ack_b_q;
    assign ram_own = ram_own_q;
    assign wr_en   = wr_en_q;
    assign wr_hive = wr_hive_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_hive_damage_ctrl.sv
// Bench for hive_damage_ctrl: table of hits with hand-computed erase addresses, scoreboarded writes,
// plus tie arbitration, vblank pause and mid-erase reset sequences.
module tb_hive_damage_ctrl;

    logic        clk_pix = 1'b0;
    logic        rst_pix, vbl, req_p, req_b;
    logic [1:0]  hive_p, hive_b;
    logic [5:0]  hx_p, hx_b, hy_p, hy_b;
    logic        ack_p, ack_b, ram_own, wr_en, busy, done;
    logic [3:0]  wr_hive;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;

    hive_damage_ctrl dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .vbl(vbl),
        .req_p(req_p), .req_b(req_b),
        .hive_p(hive_p), .hive_b(hive_b),
        .hx_p(hx_p), .hx_b(hx_b), .hy_p(hy_p), .hy_b(hy_b),
        .ack_p(ack_p), .ack_b(ack_b), .ram_own(ram_own), .wr_en(wr_en),
        .wr_hive(wr_hive), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #20 clk_pix = ~clk_pix;

    // a holds the expected addresses in issue order, first address in the top 12 bits (a[8]).
    typedef struct packed {
        logic              use_b;
        logic [1:0]        hive;
        logic [5:0]        hx;
        logic [5:0]        hy;
        logic [3:0]        n;
        logic [8:0][11:0]  a;
    } vec_t;

    typedef logic [23:0] wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   wr_seen = 0;
    int   n_done  = 0;
    vec_t tbl [7];
    vec_t tie_p, tie_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ub, input logic [1:0] h, input logic [5:0] x,
                                input logic [5:0] y, input logic [3:0] n, input logic [107:0] a);
        vec_t v;
        v.use_b = ub;
        v.hive  = h;
        v.hx    = x;
        v.hy    = y;
        v.n     = n;
        v.a     = a;
        return v;
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] h);
        return 4'b0001 << h;
    endfunction

    always @(negedge clk_pix) begin
        if (done) n_done++;
        if (wr_en) begin
            wr_seen++;
            check("ram_own_during_wr", 32'(ram_own), 32'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_wr: got hive %b addr %0d, required no write", wr_hive, wr_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_hive_addr_data", {8'h00, wr_hive, wr_addr, wr_data}, {8'h00, mon_e});
            end
        end
    end

    task automatic tick();
        @(negedge clk_pix);
        #1;
    endtask

    task automatic push_vec(input vec_t v);
        for (int j = 0; j < int'(v.n); j++)
            exp_q.push_back({oh(v.hive), v.a[8-j], 8'h00});
    endtask

    task automatic drive_req(input vec_t v, input logic on);
        if (v.use_b) begin
            req_b = on; hive_b = v.hive; hx_b = v.hx; hy_b = v.hy;
        end else begin
            req_p = on; hive_p = v.hive; hx_p = v.hx; hy_p = v.hy;
        end
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 80) begin tick(); k++; end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {12'd0, ack_p, ack_b, ram_own, wr_en, wr_hive, wr_addr, busy, done}, 32'd0);
        check({name, "_wr_data"}, 32'(wr_data), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int k, w0, d0;
        w0 = wr_seen; d0 = n_done;
        push_vec(v);
        drive_req(v, 1'b1);
        tick();
        check("ack_p", 32'(ack_p), 32'(!v.use_b));
        check("ack_b", 32'(ack_b), 32'(v.use_b));
        check("busy_at_ack", 32'(busy), 32'd1);
        drive_req(v, 1'b0);
        wait_done(k);
        check("req_to_done_cycles", 32'(k + 1), 32'd12);
        check("busy_at_done", 32'(busy), 32'd0);
        tick();
        check("done_pulses", 32'(n_done - d0), 32'd1);
        check("write_count", 32'(wr_seen - w0), 32'(v.n));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_tie(input vec_t p, input vec_t b);
        int k, w0, d0;
        w0 = wr_seen; d0 = n_done;
        push_vec(p);
        push_vec(b);
        drive_req(p, 1'b1);
        drive_req(b, 1'b1);
        tick();
        check("tie_ack_p_first", 32'(ack_p), 32'd1);
        check("tie_ack_b_held", 32'(ack_b), 32'd0);
        drive_req(p, 1'b0);
        wait_done(k);
        check("tie_first_done_cycles", 32'(k + 1), 32'd12);
        k = 0;
        while (!ack_b && k < 10) begin tick(); k++; end
        check("tie_pending_ack_delay", 32'(k), 32'd2);
        drive_req(b, 1'b0);
        wait_done(k);
        check("tie_second_done_cycles", 32'(k + 1), 32'd12);
        tick();
        check("tie_done_pulses", 32'(n_done - d0), 32'd2);
        check("tie_write_count", 32'(wr_seen - w0), 32'(p.n) + 32'(b.n));
        check("tie_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k, w0, d0, bad;

        tbl[0] = mk(1'b0, 2'd2, 6'd10, 6'd5, 4'd9,
                    {12'd233, 12'd234, 12'd235, 12'd289, 12'd290, 12'd291, 12'd345, 12'd346, 12'd347});
        tbl[1] = mk(1'b1, 2'd0, 6'd0, 6'd0, 4'd4,
                    {12'd0, 12'd1, 12'd56, 12'd57, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
        tbl[2] = mk(1'b0, 2'd3, 6'd55, 6'd38, 4'd4,
                    {12'd2126, 12'd2127, 12'd2182, 12'd2183, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
        tbl[3] = mk(1'b1, 2'd1, 6'd60, 6'd5, 4'd0,
                    {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
        tbl[4] = mk(1'b0, 2'd1, 6'd56, 6'd5, 4'd3,
                    {12'd279, 12'd335, 12'd391, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
        tbl[5] = mk(1'b1, 2'd0, 6'd20, 6'd39, 4'd3,
                    {12'd2147, 12'd2148, 12'd2149, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
        tbl[6] = mk(1'b0, 2'd2, 6'd0, 6'd20, 4'd6,
                    {12'd1064, 12'd1065, 12'd1120, 12'd1121, 12'd1176, 12'd1177, 12'd0, 12'd0, 12'd0});
        tie_p  = mk(1'b0, 2'd1, 6'd30, 6'd10, 4'd9,
                    {12'd533, 12'd534, 12'd535, 12'd589, 12'd590, 12'd591, 12'd645, 12'd646, 12'd647});
        tie_b  = mk(1'b1, 2'd3, 6'd5, 6'd20, 4'd9,
                    {12'd1068, 12'd1069, 12'd1070, 12'd1124, 12'd1125, 12'd1126, 12'd1180, 12'd1181, 12'd1182});

        rst_pix = 1'b1; vbl = 1'b1;
        req_p = 1'b0; req_b = 1'b0;
        hive_p = 2'd0; hive_b = 2'd0; hx_p = 6'd0; hx_b = 6'd0; hy_p = 6'd0; hy_b = 6'd0;
        repeat (3) tick();
        check_reset_outputs("reset_state");
        rst_pix = 1'b0;
        tick();

        do_tie(tie_p, tie_b);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // vblank drops right after the third write and returns 100 cycles later
        w0 = wr_seen; d0 = n_done;
        push_vec(tbl[0]);
        drive_req(tbl[0], 1'b1);
        tick();
        check("pause_ack_p", 32'(ack_p), 32'd1);
        drive_req(tbl[0], 1'b0);
        k = 0;
        while ((wr_seen - w0) < 3 && k < 40) begin tick(); k++; end
        check("pause_pre_writes", 32'(wr_seen - w0), 32'd3);
        vbl = 1'b0;
        bad = 0;
        repeat (100) begin
            tick();
            if (wr_en || ram_own) bad++;
        end
        check("pause_gap_quiet", 32'(bad), 32'd0);
        check("pause_busy_held", 32'(busy), 32'd1);
        vbl = 1'b1;
        wait_done(k);
        check("pause_done_seen", 32'(done), 32'd1);
        tick();
        check("pause_write_count", 32'(wr_seen - w0), 32'd9);
        check("pause_done_pulses", 32'(n_done - d0), 32'd1);
        check("pause_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // reset lands mid-erase; the aborted player grant must not bias the next tie
        w0 = wr_seen;
        push_vec(tbl[0]);
        drive_req(tbl[0], 1'b1);
        tick();
        drive_req(tbl[0], 1'b0);
        k = 0;
        while ((wr_seen - w0) < 4 && k < 40) begin tick(); k++; end
        check("rst_pre_writes", 32'(wr_seen - w0), 32'd4);
        rst_pix = 1'b1;
        exp_q.delete();
        tick();
        check_reset_outputs("rst_mid_erase");
        rst_pix = 1'b0;
        w0 = wr_seen; d0 = n_done;
        repeat (30) tick();
        check("rst_no_writes_after", 32'(wr_seen - w0), 32'd0);
        check("rst_no_done_after", 32'(n_done - d0), 32'd0);

        do_tie(tie_p, tie_b);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hive_damage_ctrl.md
HIVE_DAMAGE_CTRL -- requirements
Module: hive_damage_ctrl

Interface
REQ-001 SHALL have parameter HIVE_W, default 56: hive sprite width in pixels.
REQ-002 SHALL have parameter HIVE_H, default 39: hive sprite height in pixels.
REQ-003 SHALL have parameter ERASE_VAL, default 8'h00: pixel value written to mark a hive pixel as destroyed.
REQ-004 SHALL have port clk_pix, input, 1: 25.2MHz pixel clock, the only clock.
REQ-005 SHALL have port rst_pix, input, 1: reset, synchronous to clk_pix, active-high.
REQ-006 SHALL have port vbl, input, 1: high while sy is 480..523; the write window.
REQ-007 SHALL have ports req_p, input, 1 and req_b, input, 1: hit requests from the player bullet and the bee bomb.
REQ-008 SHALL have ports hive_p, input, 2 and hive_b, input, 2: target hive index 0..3.
REQ-009 SHALL have ports hx_p, input, 6 and hx_b, input, 6: hit x offset within the hive.
REQ-010 SHALL have ports hy_p, input, 6 and hy_b, input, 6: hit y offset within the hive.
REQ-011 SHALL have ports ack_p, output, 1 and ack_b, output, 1: one-cycle request-accepted pulses.
REQ-012 SHALL have port ram_own, output, 1: high while the controller owns the hive RAM address/write ports.
REQ-013 SHALL have port wr_en, output, 1: hive RAM write strobe.
REQ-014 SHALL have port wr_hive, output, 4: one-hot RAM select, bit n selects Hive(n+1)Ram.
REQ-015 SHALL have port wr_addr, output, 12: hive RAM address.
REQ-016 SHALL have port wr_data, output, 8: data written, always ERASE_VAL.
REQ-017 SHALL have port busy, output, 1: high from acceptance until completion.
REQ-018 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-019 SHALL register every output.
REQ-020 SHALL implement states IDLE, WAIT_BLANK, ERASE and DONE.
REQ-021 In IDLE, any req SHALL cause the controller to grant one requester, latch its hive/hx/hy, pulse that requester's ack in the next cycle, set busy, and move to WAIT_BLANK.
REQ-022 When req_p and req_b are high in the same cycle, arbitration SHALL be round-robin against the last grant; after reset the last grant SHALL be bee, so the player wins the first tie.
REQ-023 A requester SHALL hold req and its fields stable until its ack; the controller SHALL ignore req while busy, and the loser stays pending.
REQ-024 WAIT_BLANK SHALL move to ERASE on the first cycle with vbl=1.
REQ-025 ERASE SHALL visit 9 cells (dy,dx), each in -1..+1, in row-major order starting at (-1,-1), one cell per cycle while vbl=1.
REQ-026 If vbl=0 during ERASE, the controller SHALL pause: hold the cell index, drive wr_en=0 and ram_own=0, and resume at the same cell when vbl=1.
REQ-027 Cell coordinates SHALL be X=hx+dx and Y=hy+dy, computed signed; a cell SHALL be written only if 0<=X<HIVE_W and 0<=Y<HIVE_H, and a clipped cell SHALL consume its cycle with wr_en=0.
REQ-028 The address SHALL be wr_addr = Y*HIVE_W + X, 12-bit; the maximum is 2183, with no wrap.
REQ-029 The write for a visited cell SHALL appear on wr_en/wr_addr/wr_hive in the cycle after that cell is visited.
REQ-030 ram_own SHALL be high in every cycle wr_en can be high, and in the cycle after the last cell.
REQ-031 A hit centre with hx>=HIVE_W or hy>=HIVE_H SHALL still be acked and sequenced; any in-bounds neighbours are written.
REQ-032 After cell 8's write cycle, the controller SHALL enter DONE: done=1 and busy=0 for one cycle, ram_own=0, then IDLE.
REQ-033 Minimum latency SHALL be: req to ack 1 cycle; ack to first write 2 cycles with vbl already high; acceptance to done 12 cycles.

Reset
REQ-034 On rst_pix=1, the controller SHALL force state IDLE and drive all outputs to 0 (wr_data=ERASE_VAL is permitted).
REQ-035 On reset, the controller SHALL set the last grant to bee, discard any in-progress erase with no further writes and no done, and issue no ack for pending requests.

Verification
REQ-036 vbl=1, req_p with hive_p=2, hx=10, hy=5 -> ack_p next cycle; 9 writes with wr_hive=4'b0100 to addrs 233,234,235,289,290,291,345,346,347; done once.
REQ-037 req_p and req_b in the same cycle after reset -> ack_p first; after done, ack_b without req_b being re-asserted.
REQ-038 hx=0, hy=0 -> only 4 writes, addrs 0,1,56,57; hx=55, hy=38 -> addrs 2126,2127,2182,2183.
REQ-039 vbl dropped for 100 cycles after the 3rd write -> no wr_en and ram_own=0 during the gap; remaining 6 writes follow once vbl returns; exactly 9 addresses total.
REQ-040 rst_pix asserted mid-ERASE -> next cycle all outputs 0, no further writes, no done; a new req after reset is acked normally.
REQ-041 hx=60, hy=5 -> ack issued, wr_en never high, done pulses after the sequence.
